// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the piso transmitter
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/piso_bitcnt.sv
// rtl/piso_bitcnt.sv - load/decrement bit down-counter with first/last flags
module piso_bitcnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic is_first,
    output logic is_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    // Load on word acceptance, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_first = (cnt == LOAD_VAL);
    assign is_last  = (cnt == '0);

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with valid/ready load
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             direction,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic             dir_q;
    logic             accept;
    logic             is_first;
    logic             is_last;

    // The last-bit cycle can accept the next word so words run back-to-back
    assign din_ready = (state == IDLE) || is_last;
    assign accept    = din_valid && din_ready;

    piso_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (state == SHIFT),
        .is_first (is_first),
        .is_last  (is_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave SHIFT only when the last bit goes out with no new word
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (is_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture word and order on acceptance, then shift the outgoing bit away
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr    <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (accept) begin
            sr    <= din;
            dir_q <= direction;
        end else if (state == SHIFT) begin
            sr <= (dir_q == DIR_MSB_FIRST) ? (sr << 1) : (sr >> 1);
        end
    end

    // Outputs come only from registers, so reset silences them at once
    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid && ((dir_q == DIR_MSB_FIRST) ? sr[WIDTH-1] : sr[0]);
    assign sof        = sout_valid && is_first;
    assign done       = sout_valid && is_last;

endmodule
